sram_axi_slave: RTL and testbench

AXI4 slave port that fronts one synchronous single-port SRAM macro (instruction or data memory) behind the bus interconnect. It consumes the AXI transactions produced by the CPU-side masters after arbitration and turns them into SRAM chip-enable, write-enable and byte-mask cycles. Supports INCR bursts of 1–16 beats, 32-bit data and per-byte write strobes, with one outstanding transaction at a time.

---
 rtl/sram_axi_slave.sv | 184 ++++++++++++++++++
 tb/tb_sram_axi_slave.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_slave.sv
// sram_axi_slave
//   AXI4 slave in front of one synchronous single-port SRAM macro.
//   One outstanding transaction at a time; every burst is treated as INCR
//   with 4-byte beats, 1-16 beats, 32-bit data with per-byte strobes.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   AW*/W*/B*           AXI write address / data / response channels
//   AR*/R*              AXI read address / data channels
//   CEB, WEB, BWEB      SRAM chip enable, write enable, bit write mask (all active-low)
//   A, DI               SRAM word index and write data
//   DO                  SRAM read data, valid the cycle after a read access
module sram_axi_slave #(
  parameter int IDX_W = 14,
  parameter int ID_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  // write address
  input  logic [ID_W-1:0]   AWID,
  input  logic [31:0]       AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  // write data
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  // write response
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  // read address
  input  logic [ID_W-1:0]   ARID,
  input  logic [31:0]       ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  // read data
  output logic [ID_W-1:0]   RID,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  // SRAM macro
  output logic              CEB,
  output logic              WEB,
  output logic [31:0]       BWEB,
  output logic [IDX_W-1:0]  A,
  output logic [31:0]       DI,
  input  logic [31:0]       DO
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic [1:0]       state_q;
  logic [ID_W-1:0]  id_q;     // shared: only one transaction is ever in flight
  logic [3:0]       len_q;
  logic [3:0]       cnt_q;
  logic [IDX_W-1:0] idx_q;

  logic ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic [31:0] wmask_n;

  // Size/burst type are ignored; AWLEN is ignored since WLAST ends the burst.
  logic unused_ok;
  assign unused_ok = ^{AWLEN, AWSIZE, AWBURST, ARSIZE, ARBURST,
                       AWADDR[31:IDX_W+2], AWADDR[1:0],
                       ARADDR[31:IDX_W+2], ARADDR[1:0]};

  // Read has priority over a simultaneous write request.
  assign ARREADY = (state_q == IDLE);
  assign AWREADY = (state_q == IDLE) & ~ARVALID;
  assign WREADY  = (state_q == WR);
  assign RVALID  = (state_q == RD);
  assign BVALID  = (state_q == RESP);

  assign ar_hs = ARVALID & ARREADY;
  assign aw_hs = AWVALID & AWREADY;
  assign r_hs  = RVALID & RREADY;
  assign w_hs  = WVALID & WREADY;
  assign b_hs  = BVALID & BREADY;

  assign RID   = id_q;
  assign BID   = id_q;
  assign RDATA = DO;
  assign RRESP = 2'b00;
  assign BRESP = 2'b00;
  assign RLAST = (state_q == RD) && (cnt_q == len_q);

  // Byte strobe -> active-low 8-bit lane mask.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign wmask_n[8*k +: 8] = {8{~WSTRB[k]}};
  end

  // SRAM command. In RD the next word is fetched only when the current beat
  // is accepted; otherwise the same word is re-read so DO holds steady.
  always_comb begin
    CEB  = 1'b1;
    WEB  = 1'b1;
    BWEB = '1;
    A    = '0;
    DI   = '0;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          CEB = 1'b0;
          A   = ARADDR[IDX_W+1:2];
        end
      end
      RD: begin
        CEB = 1'b0;
        A   = RREADY ? idx_q + IDX_ONE : idx_q;
      end
      WR: begin
        if (WVALID) begin
          CEB  = 1'b0;
          WEB  = 1'b0;
          A    = idx_q;
          DI   = WDATA;
          BWEB = wmask_n;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_hs) begin
            state_q <= RD;
            id_q    <= ARID;
            len_q   <= ARLEN;
            cnt_q   <= '0;
            idx_q   <= ARADDR[IDX_W+1:2];
          end else if (aw_hs) begin
            state_q <= WR;
            id_q    <= AWID;
            idx_q   <= AWADDR[IDX_W+1:2];
          end
        end
        RD: begin
          if (r_hs) begin
            idx_q <= idx_q + IDX_ONE;   // wraps mod 2^IDX_W
            cnt_q <= cnt_q + 4'd1;
            if (RLAST) state_q <= IDLE;
          end
        end
        WR: begin
          if (w_hs) begin
            idx_q <= idx_q + IDX_ONE;
            if (WLAST) state_q <= RESP;
          end
        end
        RESP: begin
          if (b_hs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Directed bench for sram_axi_slave with a behavioural SRAM model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_sram_axi_slave;
  localparam int IDX_W = 14;
  localparam int ID_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [ID_W-1:0] AWID = '0, ARID = '0, BID, RID;
  logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, RDATA, BWEB, DI, DO;
  logic [3:0]  AWLEN = '0, ARLEN = '0, WSTRB = '0;
  logic [2:0]  AWSIZE = 3'd2, ARSIZE = 3'd2;
  logic [1:0]  AWBURST = 2'd1, ARBURST = 2'd1, BRESP, RRESP;
  logic AWVALID = 0, WLAST = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID, CEB, WEB;
  logic [IDX_W-1:0] A;

  int checks = 0;
  int failures = 0;

  sram_axi_slave #(.IDX_W(IDX_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
  );

  // Synchronous single-port SRAM with active-low bit mask.
  logic [31:0] mem [0:(1<<IDX_W)-1];
  initial DO = '0;
  always @(posedge clk) begin
    if (!CEB) begin
      if (!WEB) mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
      else      DO <= mem[A];
    end
  end

  task automatic drive();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ARVALID = 1'b1;
    @(negedge clk);
    checks++; if (ARREADY !== 1'b1) begin failures++; $display("FAIL rst_arready got=%b exp=1", ARREADY); end
    checks++; if (AWREADY !== 1'b0) begin failures++; $display("FAIL rst_awready_arv got=%b exp=0", AWREADY); end
    ARVALID = 1'b0;
    @(negedge clk);
    checks++; if (AWREADY !== 1'b1) begin failures++; $display("FAIL rst_awready got=%b exp=1", AWREADY); end
    checks++; if ({RVALID, BVALID, WREADY, RLAST} !== 4'b0000) begin failures++; $display("FAIL rst_valids got=%b exp=0000", {RVALID, BVALID, WREADY, RLAST}); end
    checks++; if ({CEB, WEB, BWEB} !== {2'b11, 32'hFFFF_FFFF}) begin failures++; $display("FAIL rst_sram got=%b%b %h exp=11 ffffffff", CEB, WEB, BWEB); end
    checks++; if ({A, DI, RID, BID} !== '0) begin failures++; $display("FAIL rst_zero got=%h %h %h %h exp=0", A, DI, RID, BID); end
    drive(); rst = 1'b0;
  endtask

  task automatic test_single_read();
    drive(); ARVALID = 1; ARADDR = 32'h40; ARLEN = 0; ARID = 8'h12; RREADY = 1;
    @(negedge clk);
    checks++; if ({ARREADY, CEB, WEB, A} !== {3'b101, 14'h10}) begin failures++; $display("FAIL rd1_ar got=%b%b%b %h exp=101 0010", ARREADY, CEB, WEB, A); end
    drive(); ARVALID = 0;
    @(negedge clk);
    checks++; if ({RVALID, RLAST, RRESP} !== 4'b1100) begin failures++; $display("FAIL rd1_ctl got=%b%b%b exp=1100", RVALID, RLAST, RRESP); end
    checks++; if (RDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL rd1_data got=%h exp=deadbeef", RDATA); end
    checks++; if (RID !== 8'h12) begin failures++; $display("FAIL rd1_id got=%h exp=12", RID); end
    drive(); RREADY = 0;
    @(negedge clk);
    checks++; if ({RVALID, CEB} !== 2'b01) begin failures++; $display("FAIL rd1_done got=%b%b exp=01", RVALID, CEB); end
  endtask

  task automatic test_read_burst();
    logic [5:0] pat;
    int b;
    pat = 6'b111001;   // bit i = RREADY in cycle i: 1,0,0,1,1,1
    b = 0;
    drive(); ARVALID = 1; ARADDR = 32'h100; ARLEN = 3; ARID = 8'h34;
    for (int i = 0; i < 6; i++) begin
      drive(); ARVALID = 0; RREADY = pat[i];
      @(negedge clk);
      checks++; if (RVALID !== 1'b1) begin failures++; $display("FAIL burst_valid cyc=%0d got=%b exp=1", i, RVALID); end
      checks++; if (RDATA !== 32'hA0A0_0000 + 32'(b)) begin failures++; $display("FAIL burst_data cyc=%0d got=%h exp=%h", i, RDATA, 32'hA0A0_0000 + 32'(b)); end
      checks++; if (RLAST !== (b == 3)) begin failures++; $display("FAIL burst_last cyc=%0d got=%b exp=%b", i, RLAST, (b == 3)); end
      if (pat[i]) b++;
    end
    drive(); RREADY = 0;
    @(negedge clk);
    checks++; if ({RVALID, ARREADY} !== 2'b01) begin failures++; $display("FAIL burst_end got=%b%b exp=01", RVALID, ARREADY); end
  endtask

  task automatic test_strobe_write();
    drive(); AWVALID = 1; AWADDR = 32'h8; AWLEN = 0; AWID = 8'h56;
    @(negedge clk);
    checks++; if (AWREADY !== 1'b1) begin failures++; $display("FAIL wr_awready got=%b exp=1", AWREADY); end
    drive(); AWVALID = 0; WVALID = 1; WDATA = 32'h11223344; WSTRB = 4'b0101; WLAST = 1;
    @(negedge clk);
    checks++; if ({WREADY, CEB, WEB, A} !== {3'b100, 14'h2}) begin failures++; $display("FAIL wr_cmd got=%b%b%b %h exp=100 0002", WREADY, CEB, WEB, A); end
    checks++; if ({BWEB, DI} !== {32'hFF00FF00, 32'h11223344}) begin failures++; $display("FAIL wr_mask got=%h %h exp=ff00ff00 11223344", BWEB, DI); end
    drive(); WVALID = 0; WLAST = 0; BREADY = 0;
    @(negedge clk);
    checks++; if ({BVALID, BID, BRESP} !== {1'b1, 8'h56, 2'b00}) begin failures++; $display("FAIL wr_b got=%b %h %b exp=1 56 00", BVALID, BID, BRESP); end
    checks++; if ({WREADY, CEB} !== 2'b01) begin failures++; $display("FAIL wr_b_idle got=%b%b exp=01", WREADY, CEB); end
    drive(); BREADY = 1;   // one stall cycle first, then accept
    @(negedge clk);
    checks++; if ({BVALID, BID} !== {1'b1, 8'h56}) begin failures++; $display("FAIL wr_b_hold got=%b %h exp=1 56", BVALID, BID); end
    drive(); BREADY = 0;
    @(negedge clk);
    checks++; if (BVALID !== 1'b0) begin failures++; $display("FAIL wr_b_drop got=%b exp=0", BVALID); end
    checks++; if (mem[2] !== 32'hFF22FF44) begin failures++; $display("FAIL wr_mem got=%h exp=ff22ff44", mem[2]); end
  endtask

  task automatic test_simultaneous();
    drive(); ARVALID = 1; ARADDR = 32'h8; ARLEN = 0; ARID = 8'h01;
    AWVALID = 1; AWADDR = 32'hC; AWID = 8'h02; RREADY = 1;
    @(negedge clk);
    checks++; if ({ARREADY, AWREADY} !== 2'b10) begin failures++; $display("FAIL sim_ready got=%b%b exp=10", ARREADY, AWREADY); end
    drive(); ARVALID = 0;
    @(negedge clk);
    checks++; if ({RVALID, RLAST, RDATA} !== {2'b11, 32'hFF22FF44}) begin failures++; $display("FAIL sim_rd got=%b%b %h exp=11 ff22ff44", RVALID, RLAST, RDATA); end
    checks++; if (AWREADY !== 1'b0) begin failures++; $display("FAIL sim_aw_busy got=%b exp=0", AWREADY); end
    drive(); RREADY = 0;
    @(negedge clk);
    checks++; if (AWREADY !== 1'b1) begin failures++; $display("FAIL sim_aw_accept got=%b exp=1", AWREADY); end
    drive(); AWVALID = 0; WVALID = 1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WLAST = 1;
    @(negedge clk);
    checks++; if ({WREADY, A} !== {1'b1, 14'h3}) begin failures++; $display("FAIL sim_w got=%b %h exp=1 0003", WREADY, A); end
    drive(); WVALID = 0; WLAST = 0; BREADY = 1;
    @(negedge clk);
    checks++; if ({BVALID, BID} !== {1'b1, 8'h02}) begin failures++; $display("FAIL sim_b got=%b %h exp=1 02", BVALID, BID); end
    drive(); BREADY = 0;
    @(negedge clk);
    checks++; if (mem[3] !== 32'hCAFEF00D) begin failures++; $display("FAIL sim_mem got=%h exp=cafef00d", mem[3]); end
  endtask

  task automatic test_wrap();
    drive(); ARVALID = 1; ARADDR = 32'hFFFC; ARLEN = 1; ARID = 8'h07; RREADY = 1;
    drive(); ARVALID = 0;
    @(negedge clk);
    checks++; if ({RDATA, RLAST} !== {32'h11112222, 1'b0}) begin failures++; $display("FAIL wrap_b0 got=%h %b exp=11112222 0", RDATA, RLAST); end
    drive();
    @(negedge clk);
    checks++; if ({RDATA, RLAST, RID} !== {32'h33334444, 1'b1, 8'h07}) begin failures++; $display("FAIL wrap_b1 got=%h %b %h exp=33334444 1 07", RDATA, RLAST, RID); end
    drive(); RREADY = 0;
    @(negedge clk);
    checks++; if (RVALID !== 1'b0) begin failures++; $display("FAIL wrap_end got=%b exp=0", RVALID); end
  endtask

  task automatic test_reset_mid_write();
    drive(); AWVALID = 1; AWADDR = 32'h80; AWLEN = 3; AWID = 8'h09;
    drive(); AWVALID = 0; WVALID = 1; WSTRB = 4'hF; WLAST = 0; WDATA = 32'h1;
    drive(); WDATA = 32'h2;
    drive(); rst = 1; WVALID = 0;
    @(negedge clk);
    checks++; if ({WREADY, CEB, BVALID} !== 3'b010) begin failures++; $display("FAIL mid_rst got=%b%b%b exp=010", WREADY, CEB, BVALID); end
    drive(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({BVALID, WREADY} !== 2'b00) begin failures++; $display("FAIL mid_no_b cyc=%0d got=%b%b exp=00", i, BVALID, WREADY); end
    end
    checks++; if ({mem[32'h20], mem[32'h21], mem[32'h22]} !== {32'h1, 32'h2, 32'h0}) begin failures++; $display("FAIL mid_mem got=%h %h %h exp=1 2 0", mem[32'h20], mem[32'h21], mem[32'h22]); end
    drive(); AWVALID = 1; AWADDR = 32'h90; AWLEN = 0; AWID = 8'h0A;
    drive(); AWVALID = 0; WVALID = 1; WDATA = 32'h55AA55AA; WLAST = 1;
    drive(); WVALID = 0; WLAST = 0; BREADY = 1;
    @(negedge clk);
    checks++; if ({BVALID, BID} !== {1'b1, 8'h0A}) begin failures++; $display("FAIL fresh_b got=%b %h exp=1 0a", BVALID, BID); end
    drive(); BREADY = 0;
    @(negedge clk);
    checks++; if ({BVALID, mem[32'h24]} !== {1'b0, 32'h55AA55AA}) begin failures++; $display("FAIL fresh_mem got=%b %h exp=0 55aa55aa", BVALID, mem[32'h24]); end
  endtask

  initial begin
    for (int i = 0; i < (1 << IDX_W); i++) mem[i] = '0;
    mem[32'h10]   = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) mem[32'h40 + i] = 32'hA0A0_0000 + 32'(i);
    mem[2]        = 32'hFFFF_FFFF;
    mem[32'h3FFF] = 32'h11112222;
    mem[0]        = 32'h33334444;
    test_reset();
    test_single_read();
    test_read_burst();
    test_strobe_write();
    test_simultaneous();
    test_wrap();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
